// File: rtl/stage_nhead.sv
// Multi-head accumulate/reduce stage: every accepted sample is scaled and biased into one
// accumulator per head, then the heads are summed one per cycle and saturated to WIDTH.

package stage_nhead_pkg;
    localparam int att_width = 16;
endpackage

module stage_nhead
    import stage_nhead_pkg::*;
#(
    parameter int WIDTH    = att_width,
    parameter int NUM_HEAD = 2,
    parameter int SEQ_LEN  = 4,
    parameter int W_BASE   = 1,
    parameter int W_STEP   = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [WIDTH-1:0]          i_stage,
    input  logic [NUM_HEAD*WIDTH-1:0] bias,
    output logic                      i_ready,
    output logic [WIDTH-1:0]          o_stage,
    output logic                      end_s
);

    localparam int SEQ_CW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int IDX_W  = (NUM_HEAD > 1) ? $clog2(NUM_HEAD) : 1;
    localparam int ACC_W  = 2 * WIDTH + $clog2(SEQ_LEN) + 2;
    localparam int SUM_W  = ACC_W + $clog2(NUM_HEAD);

    localparam logic [SEQ_CW-1:0] LAST_CNT = SEQ_CW'(SEQ_LEN - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_HEAD - 1);

    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state;
    logic [SEQ_CW-1:0]        cnt;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc  [NUM_HEAD];
    logic signed [ACC_W-1:0]  term [NUM_HEAD];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [ACC_W-1:0]  acc_sel;
    logic [WIDTH-1:0]         sat_val;

    // Handshake: a sample transfers on a rising edge where en=1 and i_ready=1; i_ready is
    // purely a function of state, so a producer may look at it before deciding to raise en.
    assign i_ready = (state == ACCUM);

    for (genvar h = 0; h < NUM_HEAD; h++) begin : g_head
        localparam logic signed [WIDTH-1:0] WEIGHT = WIDTH'(W_BASE + h * W_STEP);
        logic signed [WIDTH-1:0]   b_h;
        logic signed [WIDTH-1:0]   x_s;
        logic signed [2*WIDTH-1:0] prod;
        assign b_h     = bias[h*WIDTH +: WIDTH];
        assign x_s     = i_stage;
        assign prod    = x_s * WEIGHT;
        assign term[h] = ACC_W'(prod) + ACC_W'(b_h);
    end

    // Reduction walks the heads in order; the last head is folded straight into the
    // saturated result rather than stored back into sum.
    always_comb begin
        acc_sel  = acc[idx];
        sum_next = sum + SUM_W'(acc_sel);
        if (sum_next > SAT_MAX) begin
            sat_val = SAT_MAX[WIDTH-1:0];
        end else if (sum_next < SAT_MIN) begin
            sat_val = SAT_MIN[WIDTH-1:0];
        end else begin
            sat_val = sum_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ACCUM;
            cnt     <= '0;
            idx     <= '0;
            sum     <= '0;
            o_stage <= '0;
            end_s   <= 1'b0;
            for (int h = 0; h < NUM_HEAD; h++) begin
                acc[h] <= '0;
            end
        end else begin
            end_s <= 1'b0;
            case (state)
                ACCUM: begin
                    if (en) begin
                        for (int h = 0; h < NUM_HEAD; h++) begin
                            acc[h] <= acc[h] + term[h];
                        end
                        if (cnt == LAST_CNT) begin
                            cnt   <= '0;
                            state <= REDUCE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                REDUCE: begin
                    if (en) begin
                        if (idx == LAST_IDX) begin
                            o_stage <= sat_val;
                            end_s   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            sum <= sum_next;
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    for (int h = 0; h < NUM_HEAD; h++) begin
                        acc[h] <= '0;
                    end
                    sum   <= '0;
                    idx   <= '0;
                    state <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_nhead.sv
// Bench for stage_nhead: three instances (default, 8-bit saturating, 4-head single-sample)
// driven pass by pass; expected results come from a behavioural model via per-DUT queues.

module tb_stage_nhead;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic        en_a;
    logic [15:0] x_a;
    logic [31:0] bias_a;
    logic        rdy_a;
    logic [15:0] o_a;
    logic        end_a;

    logic        en_b;
    logic [7:0]  x_b;
    logic [15:0] bias_b;
    logic        rdy_b;
    logic [7:0]  o_b;
    logic        end_b;

    logic        en_c;
    logic [15:0] x_c;
    logic [63:0] bias_c;
    logic        rdy_c;
    logic [15:0] o_c;
    logic        end_c;

    logic [15:0] exp_a[$];
    logic [7:0]  exp_b[$];
    logic [15:0] exp_c[$];
    logic [15:0] last_a;

    stage_nhead dut_a (
        .clk(clk), .rstn(rstn), .en(en_a), .i_stage(x_a), .bias(bias_a),
        .i_ready(rdy_a), .o_stage(o_a), .end_s(end_a)
    );

    stage_nhead #(.WIDTH(8), .NUM_HEAD(2), .SEQ_LEN(4), .W_BASE(127), .W_STEP(0)) dut_b (
        .clk(clk), .rstn(rstn), .en(en_b), .i_stage(x_b), .bias(bias_b),
        .i_ready(rdy_b), .o_stage(o_b), .end_s(end_b)
    );

    stage_nhead #(.WIDTH(16), .NUM_HEAD(4), .SEQ_LEN(1), .W_BASE(1), .W_STEP(1)) dut_c (
        .clk(clk), .rstn(rstn), .en(en_c), .i_stage(x_c), .bias(bias_c),
        .i_ready(rdy_c), .o_stage(o_c), .end_s(end_c)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model: bs holds bias per sample per head, flattened as [i*nh + h].
    function automatic longint model(input int width, input int nh, input int wbase,
                                     input int wstep, input int xs[$], input int bs[$]);
        longint total;
        longint acc;
        longint mx;
        int     w;
        total = 0;
        mx = (longint'(1) <<< (width - 1)) - 1;
        for (int h = 0; h < nh; h++) begin
            w = wbase + h * wstep;
            w = (w <<< (32 - width)) >>> (32 - width);
            acc = 0;
            for (int i = 0; i < xs.size(); i++) begin
                acc += longint'(xs[i]) * w + bs[i*nh + h];
            end
            total += acc;
        end
        if (total > mx) total = mx;
        else if (total < -mx - 1) total = -mx - 1;
        return total;
    endfunction

    // One pass on dut_a: optional en=0 gap before sample 2 and at the start of REDUCE;
    // en stays high with junk inputs through REDUCE and DONE, which must not be absorbed.
    task automatic pass_a(input int xs[$], input int bs[$], input int acc_stall,
                          input int red_stall, input int exp_cyc, input string name);
        int t0;
        int n;
        logic [15:0] e;
        t0 = 0;
        e  = '0;
        for (int i = 0; i < xs.size(); i++) begin
            if (i == 2) begin
                repeat (acc_stall) begin
                    en_a = 1'b0; x_a = 16'($urandom); bias_a = $urandom;
                    @(negedge clk);
                    checks++;
                    if (rdy_a !== 1'b1 || end_a !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_accum_stall: got rdy=%b end=%b expected rdy=1 end=0", name, rdy_a, end_a);
                    end
                end
            end
            en_a = 1'b1; x_a = 16'(xs[i]); bias_a = {16'(bs[2*i+1]), 16'(bs[2*i])};
            @(negedge clk);
            if (i == 0) t0 = cyc;
        end
        en_a = 1'b0;
        exp_a.push_back(16'(model(16, 2, 1, 1, xs, bs)));
        checks++;
        if (rdy_a !== 1'b0 || o_a !== last_a) begin
            errors++;
            $display("FAIL %s_enter_reduce: got rdy=%b o=%0d expected rdy=0 o=%0d", name, rdy_a, $signed(o_a), $signed(last_a));
        end
        repeat (red_stall) begin
            x_a = 16'($urandom);
            @(negedge clk);
            checks++;
            if (end_a !== 1'b0 || rdy_a !== 1'b0) begin
                errors++;
                $display("FAIL %s_reduce_stall: got end=%b rdy=%b expected end=0 rdy=0", name, end_a, rdy_a);
            end
        end
        en_a = 1'b1;
        n = 0;
        while (end_a !== 1'b1 && n < 16) begin
            x_a = 16'($urandom); bias_a = $urandom;
            @(negedge clk);
            n++;
            checks++;
            if (rdy_a !== 1'b0) begin
                errors++;
                $display("FAIL %s_ready_low: got %b expected 0", name, rdy_a);
            end
        end
        checks++;
        if (end_a !== 1'b1) begin
            errors++;
            e = exp_a.pop_front();
            $display("FAIL %s_end_timeout: got no end_s expected end_s within 16 cycles", name);
        end else begin
            e = exp_a.pop_front();
            if (o_a !== e) begin
                errors++;
                $display("FAIL %s_result: got %0d expected %0d", name, $signed(o_a), $signed(e));
            end
            checks++;
            if (cyc - t0 != exp_cyc) begin
                errors++;
                $display("FAIL %s_latency: got %0d expected %0d", name, cyc - t0, exp_cyc);
            end
        end
        x_a = 16'($urandom); bias_a = $urandom;
        @(negedge clk);
        en_a = 1'b0;
        checks++;
        if (end_a !== 1'b0 || rdy_a !== 1'b1 || o_a !== e) begin
            errors++;
            $display("FAIL %s_after_done: got end=%b rdy=%b o=%0d expected end=0 rdy=1 o=%0d",
                     name, end_a, rdy_a, $signed(o_a), $signed(e));
        end
        last_a = e;
    endtask

    task automatic basic_queues(output int xs[$], output int bs[$]);
        xs = {};
        bs = {};
        for (int i = 0; i < 4; i++) begin
            xs.push_back(i + 1);
            bs.push_back(i + 4);
            bs.push_back(i + 4);
        end
    endtask

    task automatic test_reset();
        int xs[$];
        en_a = 0; x_a = '0; bias_a = '0;
        en_b = 0; x_b = '0; bias_b = '0;
        en_c = 0; x_c = '0; bias_c = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_a, end_a, rdy_a} !== {16'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_a: got o=%0d end=%b rdy=%b expected o=0 end=0 rdy=1", o_a, end_a, rdy_a);
        end
        checks++;
        if ({o_b, end_b, rdy_b} !== {8'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_b: got o=%0d end=%b rdy=%b expected o=0 end=0 rdy=1", o_b, end_b, rdy_b);
        end
        checks++;
        if ({o_c, end_c, rdy_c} !== {16'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_c: got o=%0d end=%b rdy=%b expected o=0 end=0 rdy=1", o_c, end_c, rdy_c);
        end
        rstn = 1'b1;
        @(negedge clk);
        last_a = '0;
    endtask

    task automatic test_basic();
        int xs[$];
        int bs[$];
        basic_queues(xs, bs);
        pass_a(xs, bs, 0, 0, 5, "basic");
        checks++;
        if (o_a !== 16'd74) begin
            errors++;
            $display("FAIL basic_const: got %0d expected 74", $signed(o_a));
        end
    endtask

    task automatic test_stall();
        int xs[$];
        int bs[$];
        basic_queues(xs, bs);
        pass_a(xs, bs, 3, 2, 10, "stall");
        checks++;
        if (o_a !== 16'd74) begin
            errors++;
            $display("FAIL stall_const: got %0d expected 74", $signed(o_a));
        end
    endtask

    task automatic test_random();
        int xs[$];
        int bs[$];
        for (int p = 0; p < 4; p++) begin
            xs = {};
            bs = {};
            for (int i = 0; i < 4; i++) begin
                xs.push_back(int'($urandom_range(0, 65535)) - 32768);
                bs.push_back(int'($urandom_range(0, 65535)) - 32768);
                bs.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            pass_a(xs, bs, p % 2, 0, 5 + (p % 2), "random");
        end
    endtask

    task automatic pass_b(input int x, input logic [7:0] const_exp);
        int xs[$];
        int bs[$];
        int n;
        logic [7:0] e;
        xs = {};
        bs = {};
        for (int i = 0; i < 4; i++) begin
            xs.push_back(x);
            bs.push_back(0);
            bs.push_back(0);
            en_b = 1'b1; x_b = 8'(x); bias_b = '0;
            @(negedge clk);
        end
        exp_b.push_back(8'(model(8, 2, 127, 0, xs, bs)));
        n = 0;
        while (end_b !== 1'b1 && n < 16) begin
            x_b = 8'($urandom); bias_b = 16'($urandom);
            @(negedge clk);
            n++;
        end
        e = exp_b.pop_front();
        checks++;
        if (end_b !== 1'b1 || o_b !== e || o_b !== const_exp) begin
            errors++;
            $display("FAIL sat_result: got %0d expected %0d", $signed(o_b), $signed(e));
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL sat_latency: got %0d expected 2", n);
        end
        @(negedge clk);
        en_b = 1'b0;
    endtask

    task automatic test_saturation();
        pass_b(127, 8'sd127);
        pass_b(-128, 8'h80);
    endtask

    task automatic pass_c(input int x, input int b);
        int xs[$];
        int bs[$];
        int n;
        logic [15:0] e;
        xs = {x};
        bs = {b, b, b, b};
        checks++;
        if (rdy_c !== 1'b1) begin
            errors++;
            $display("FAIL seq1_ready: got %b expected 1", rdy_c);
        end
        en_c = 1'b1; x_c = 16'(x); bias_c = {4{16'(b)}};
        @(negedge clk);
        exp_c.push_back(16'(model(16, 4, 1, 1, xs, bs)));
        n = 0;
        while (end_c !== 1'b1 && n < 16) begin
            x_c = 16'($urandom); bias_c = {$urandom, $urandom};
            @(negedge clk);
            n++;
        end
        e = exp_c.pop_front();
        checks++;
        if (end_c !== 1'b1 || o_c !== e) begin
            errors++;
            $display("FAIL seq1_result: got %0d expected %0d", $signed(o_c), $signed(e));
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL seq1_latency: got %0d expected 4", n);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        pass_c(3, 1);
        checks++;
        if (o_c !== 16'd34) begin
            errors++;
            $display("FAIL seq1_const: got %0d expected 34", $signed(o_c));
        end
        pass_c(3, 1);
        pass_c(-5, 2);
        en_c = 1'b0;
    endtask

    task automatic test_reset_mid_pass();
        int xs[$];
        int bs[$];
        basic_queues(xs, bs);
        for (int i = 0; i < 4; i++) begin
            en_a = 1'b1; x_a = 16'(xs[i]); bias_a = {16'(bs[2*i+1]), 16'(bs[2*i])};
            @(negedge clk);
        end
        x_a = 16'($urandom);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (o_a !== 16'h0 || end_a !== 1'b0 || rdy_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got o=%0d end=%b rdy=%b expected o=0 end=0 rdy=1", $signed(o_a), end_a, rdy_a);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (end_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_pulse: got %b expected 0", end_a);
            end
        end
        rstn = 1'b1;
        en_a = 1'b0;
        last_a = '0;
        @(negedge clk);
        pass_a(xs, bs, 0, 0, 5, "post_reset");
        checks++;
        if (o_a !== 16'd74) begin
            errors++;
            $display("FAIL post_reset_const: got %0d expected 74", $signed(o_a));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_saturation();
        test_back_to_back();
        test_reset_mid_pass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_nhead.md
STAGE_NHEAD -- requirements
Module: stage_nhead

Interface
REQ-001 SHALL have parameter WIDTH, default att_width (definition package), signed data width of input, bias and output.
REQ-002 SHALL have parameter NUM_HEAD, default 2, number of parallel heads, legal range 1..16.
REQ-003 SHALL have parameter SEQ_LEN, default 4, samples per stage pass, legal range 1..256.
REQ-004 SHALL have parameter W_BASE, default 1, signed weight of head 0.
REQ-005 SHALL have parameter W_STEP, default 1, weight of head h = W_BASE + h*W_STEP, truncated to signed WIDTH.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port en  input  1  enable and valid: sample/advance qualifier.
REQ-009 SHALL have port i_stage  input  WIDTH  signed input sample.
REQ-010 SHALL have port bias  input  NUM_HEAD*WIDTH  signed per-head bias, head h at bits [h*WIDTH +: WIDTH].
REQ-011 SHALL have port i_ready  output  1  high when a sample can be accepted (state ACCUM).
REQ-012 SHALL have port o_stage  output  WIDTH  signed saturated stage result, held between passes.
REQ-013 SHALL have port end_s  output  1  one-cycle pulse marking new o_stage.

Function
REQ-014 SHALL implement FSM states ACCUM, REDUCE, DONE; reset state ACCUM.
REQ-015 SHALL accept a sample on a rising edge iff en=1 and state=ACCUM; i_ready SHALL equal (state==ACCUM), independent of en.
REQ-016 SHALL, per accepted sample, update every head h: acc[h] <= acc[h] + i_stage*weight[h] + bias[h], signed, all heads in the same edge.
REQ-017 SHALL size each accumulator ACC_W = 2*WIDTH + clog2(SEQ_LEN) + 2 bits so no internal overflow; the reduce sum SHALL use ACC_W + clog2(NUM_HEAD) bits.
REQ-018 SHALL count accepted samples 0..SEQ_LEN-1; the edge accepting sample SEQ_LEN-1 SHALL move state to REDUCE and clear the counter.
REQ-019 SHALL in REDUCE, on each edge with en=1, add acc[idx] to sum and increment idx, head 0 first; en=0 SHALL freeze idx and sum.
REQ-020 SHALL on the REDUCE edge adding head NUM_HEAD-1 register o_stage <= saturate(sum + acc[NUM_HEAD-1]) to [-2^(WIDTH-1), 2^(WIDTH-1)-1], set end_s=1, enter DONE.
REQ-021 SHALL in DONE clear all acc, sum and idx, and on the next edge return to ACCUM regardless of en; end_s SHALL be high exactly the DONE cycle.
REQ-022 SHALL give latency: end_s high in the cycle after edge k+NUM_HEAD, where k is the edge accepting the last sample, when en stays 1.
REQ-023 SHALL ignore i_stage and bias while not in ACCUM or while en=0; ACCUM with en=0 SHALL hold all state.
REQ-024 SHALL hold o_stage unchanged except at the REQ-020 edge.
REQ-025 SHALL with SEQ_LEN=1 enter REDUCE on every accepted sample; NUM_HEAD=1 SHALL spend one REDUCE cycle.

Reset
REQ-026 SHALL on rstn=0, asynchronously: state=ACCUM, counter=0, idx=0, all acc=0, sum=0, o_stage=0, end_s=0, i_ready=1.
REQ-027 SHALL on reset asserted mid-pass (ACCUM, REDUCE or DONE) discard the partial pass; no end_s pulse for it.
REQ-028 SHALL resume normal operation on the first rising edge after rstn deasserts.

Verification
REQ-029 Default params (WIDTH=16, NUM_HEAD=2, SEQ_LEN=4, weights 1,2), en=1, i_stage 1,2,3,4 on consecutive edges, bias both heads 4,5,6,7 -> acc 32 and 42, o_stage=74, end_s one cycle, 2 cycles after last sample edge.
REQ-030 Same stimulus with en=0 for 3 cycles between samples 2 and 3 and 2 cycles during REDUCE -> o_stage=74, end_s delayed by exactly 5 cycles; i_ready low during REDUCE/DONE.
REQ-031 WIDTH=8, NUM_HEAD=2, W_BASE=127, W_STEP=0, i_stage=127 x4, bias 0 -> o_stage=127; i_stage=-128 x4 -> o_stage=-128.
REQ-032 NUM_HEAD=4, SEQ_LEN=1, weights 1..4, i_stage=3, bias {1,1,1,1} -> o_stage=34, end_s 4 cycles after sample edge, back-to-back pass repeats 34.
REQ-033 rstn pulsed low during REDUCE of a pass -> o_stage=0, no end_s; next full pass from REQ-029 -> o_stage=74.
REQ-034 Samples driven while state REDUCE/DONE with en=1 -> not accumulated; next pass result unaffected.
